// File: rtl/fft_quad_pkg.sv
// Shared constants for the fft_quad datapath and its frame sequencer.
package fft_quad_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned IN_W  = 30;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned K_W   = 14;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/fft_frame_cnt.sv
// Loadable, clearable modulo-LIMIT counter with a terminal-count flag.
// tc is high in the cycle an increment takes the count from LIMIT-1 back to 0.
module fft_frame_cnt #(
    parameter int unsigned W     = 15,
    parameter int unsigned LIMIT = 16384
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    assign tc = inc && (cnt == LAST);

    // Count register: clear beats load beats increment; wraps on terminal count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tc) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around fft_quad: gates ADC samples into FRAME_LEN-sample
// frames, forwards FRAME_LEN result beats per frame, tracks completed frames,
// and supports continuous capture, stop requests and a drain timeout.
module fft_frame_ctrl
    import fft_quad_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16384,
    parameter int unsigned CNT_W     = 15,
    parameter int unsigned TIMEOUT   = 65536,
    parameter int unsigned NF_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              cont_mode,
    input  logic [NF_W-1:0]   n_frames,
    input  logic              adc_valid,
    input  logic [IN_W-1:0]   adc_data_0,
    input  logic [IN_W-1:0]   adc_data_1,
    input  logic [IN_W-1:0]   adc_data_2,
    input  logic [IN_W-1:0]   adc_data_3,
    output logic [IN_W-1:0]   fft_data_in_0,
    output logic [IN_W-1:0]   fft_data_in_1,
    output logic [IN_W-1:0]   fft_data_in_2,
    output logic [IN_W-1:0]   fft_data_in_3,
    output logic              fft_s_valid,
    input  logic              fft_m_valid,
    input  logic [K_W-1:0]    fft_k,
    input  logic [OUT_W-1:0]  fft_data_out_0,
    input  logic [OUT_W-1:0]  fft_data_out_1,
    input  logic [OUT_W-1:0]  fft_data_out_2,
    input  logic [OUT_W-1:0]  fft_data_out_3,
    output logic [OUT_W-1:0]  m_data_0,
    output logic [OUT_W-1:0]  m_data_1,
    output logic [OUT_W-1:0]  m_data_2,
    output logic [OUT_W-1:0]  m_data_3,
    output logic [K_W-1:0]    m_k,
    output logic              m_valid,
    output logic              m_last,
    output logic              busy,
    output logic [NF_W-1:0]   frame_cnt,
    output logic              timeout_err,
    output logic              stray_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            stop_pending;
    logic [TO_W-1:0] idle_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] res_cnt;
    logic            smp_tc;
    logic            res_tc;
    logic            start_acc;
    logic            smp_acc;
    logic            res_acc;
    logic            idle_hit;
    logic            rearm;
    logic [NF_W:0]   frame_inc;

    assign start_acc = (state == IDLE) && start;
    assign smp_acc   = (state == FEED) && adc_valid;
    assign res_acc   = (state == DRAIN) && fft_m_valid;
    // Hit on the TIMEOUT-th consecutive empty drain cycle.
    assign idle_hit  = (state == DRAIN) && !fft_m_valid && (idle_cnt == TO_W'(TIMEOUT - 1));
    assign busy      = (state != IDLE);

    // Frame count after the current frame completes, one bit wider so the limit
    // compare cannot be fooled by wrap-around.
    assign frame_inc = {1'b0, frame_cnt} + {{NF_W{1'b0}}, 1'b1};
    // A stop arriving with the final beat counts as already pending.
    assign rearm = cont_mode && !stop_pending && !stop &&
                   ((n_frames == '0) || (frame_inc < {1'b0, n_frames}));

    fft_frame_cnt #(
        .W     (CNT_W),
        .LIMIT (FRAME_LEN)
    ) u_smp_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (start_acc),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .inc      (smp_acc),
        .cnt      (smp_cnt),
        .tc       (smp_tc)
    );

    fft_frame_cnt #(
        .W     (CNT_W),
        .LIMIT (FRAME_LEN)
    ) u_res_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (start_acc || idle_hit),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .inc      (res_acc),
        .cnt      (res_cnt),
        .tc       (res_tc)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FEED;
            FEED:    if (smp_tc) state_nxt = DRAIN;
            DRAIN: begin
                if (res_tc) begin
                    state_nxt = rearm ? FEED : IDLE;
                end else if (idle_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, stop latch, frame counter and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            frame_cnt    <= '0;
            timeout_err  <= 1'b0;
            stray_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fft_m_valid && (state != DRAIN)) stray_err <= 1'b1;
            if (stop && (state != IDLE)) stop_pending <= 1'b1;
            if (res_tc) begin
                frame_cnt <= frame_inc[NF_W-1:0];
                if (!rearm) stop_pending <= 1'b0;
            end
            if (idle_hit) begin
                timeout_err  <= 1'b1;
                stop_pending <= 1'b0;
            end
            // A new run starts from a clean slate.
            if (start_acc) begin
                frame_cnt    <= '0;
                timeout_err  <= 1'b0;
                stray_err    <= 1'b0;
                stop_pending <= 1'b0;
            end
        end
    end

    // Drain idle counter; restarts on every result beat and outside DRAIN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else if ((state != DRAIN) || fft_m_valid) begin
            idle_cnt <= '0;
        end else if (!idle_hit) begin
            idle_cnt <= idle_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Input side: one-cycle registered pass-through of accepted ADC samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fft_s_valid   <= 1'b0;
            fft_data_in_0 <= '0;
            fft_data_in_1 <= '0;
            fft_data_in_2 <= '0;
            fft_data_in_3 <= '0;
        end else begin
            fft_s_valid <= smp_acc;
            if (smp_acc) begin
                fft_data_in_0 <= adc_data_0;
                fft_data_in_1 <= adc_data_1;
                fft_data_in_2 <= adc_data_2;
                fft_data_in_3 <= adc_data_3;
            end
        end
    end

    // Output side: one-cycle registered forwarding of result beats in DRAIN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_k      <= '0;
            m_data_0 <= '0;
            m_data_1 <= '0;
            m_data_2 <= '0;
            m_data_3 <= '0;
        end else begin
            m_valid <= res_acc;
            m_last  <= res_tc;
            if (res_acc) begin
                m_k      <= fft_k;
                m_data_0 <= fft_data_out_0;
                m_data_1 <= fft_data_out_1;
                m_data_2 <= fft_data_out_2;
                m_data_3 <= fft_data_out_3;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a fixed-latency fft_quad stand-in.
module tb_fft_frame_ctrl;
    import fft_quad_pkg::*;

    localparam int unsigned FL  = 16;
    localparam int unsigned TO  = 32;
    localparam int unsigned LAT = 40;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0, cont_mode = 1'b0;
    logic [15:0] n_frames = '0;
    logic adc_valid = 1'b0;
    logic [IN_W-1:0] adc_d0 = '0, adc_d1 = '0, adc_d2 = '0, adc_d3 = '0;
    logic [IN_W-1:0] fin0, fin1, fin2, fin3;
    logic fft_s_valid;
    logic fft_m_valid = 1'b0;
    logic [K_W-1:0] fft_k = '0;
    logic [OUT_W-1:0] fo0 = '0, fo1 = '0, fo2 = '0, fo3 = '0;
    logic [OUT_W-1:0] md0, md1, md2, md3;
    logic [K_W-1:0] m_k;
    logic m_valid, m_last, busy, timeout_err, stray_err;
    logic [15:0] frame_cnt;

    fft_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(5), .TIMEOUT(TO), .NF_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .cont_mode(cont_mode),
        .n_frames(n_frames), .adc_valid(adc_valid),
        .adc_data_0(adc_d0), .adc_data_1(adc_d1), .adc_data_2(adc_d2), .adc_data_3(adc_d3),
        .fft_data_in_0(fin0), .fft_data_in_1(fin1), .fft_data_in_2(fin2), .fft_data_in_3(fin3),
        .fft_s_valid(fft_s_valid), .fft_m_valid(fft_m_valid), .fft_k(fft_k),
        .fft_data_out_0(fo0), .fft_data_out_1(fo1), .fft_data_out_2(fo2), .fft_data_out_3(fo3),
        .m_data_0(md0), .m_data_1(md1), .m_data_2(md2), .m_data_3(md3), .m_k(m_k),
        .m_valid(m_valid), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Stimulus knobs; each written by the main process only.
    int adc_mode = 0;       // 0 off, 1 always, 2 pattern 1,0,0, 3 random
    int res_limit = FL;     // results the fft stand-in emits per frame
    int stop_now_cnt = 0, stop_last_cnt = 0, stray_cnt = 0;

    // Observation counters; written by the monitor only.
    int n_sv = 0, n_mv = 0, n_last = 0;

    // Reference model state.
    bit running = 0, feeding = 0, stop_req = 0, exp_terr = 0, exp_serr = 0;
    int got = 0, beats = 0, idle = 0, frames = 0;
    logic [4*IN_W-1:0] exp_s[$];
    logic [270:0]      exp_m[$];

    task automatic chk(input string name, input logic [270:0] act, input logic [270:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ADC source: a new random sample every cycle, strobe shaped by adc_mode.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (adc_mode)
                1: adc_valid = 1'b1;
                2: adc_valid = (ph == 0);
                3: adc_valid = 1'($urandom_range(0, 1));
                default: adc_valid = 1'b0;
            endcase
            ph = (ph + 1) % 3;
            adc_d0 = IN_W'($urandom); adc_d1 = IN_W'($urandom);
            adc_d2 = IN_W'($urandom); adc_d3 = IN_W'($urandom);
        end
    end

    // fft_quad stand-in: a frame's results start LAT cycles after its first
    // sample, but never before the frame is complete; also owns stop.
    initial begin
        int cyc = 0, sv_n = 0, first_cyc = 0, burst_start = -1, burst_i = 0;
        int seen_stop = 0, seen_last = 0, seen_stray = 0;
        forever begin
            @(negedge clk);
            cyc++;
            stop = 1'b0;
            fft_m_valid = 1'b0;
            fft_k = K_W'($urandom);
            fo0 = {$urandom, $urandom}; fo1 = {$urandom, $urandom};
            fo2 = {$urandom, $urandom}; fo3 = {$urandom, $urandom};
            if (!resetn) begin
                sv_n = 0;
                burst_start = -1;
            end else begin
                if (fft_s_valid) begin
                    if (sv_n == 0) first_cyc = cyc;
                    sv_n++;
                    if (sv_n == FL) begin
                        sv_n = 0;
                        burst_i = 0;
                        burst_start = (first_cyc + LAT > cyc + 2) ? first_cyc + LAT : cyc + 2;
                    end
                end
                if (stop_now_cnt != seen_stop) begin
                    seen_stop = stop_now_cnt;
                    stop = 1'b1;
                end
                if (stray_cnt != seen_stray) begin
                    seen_stray = stray_cnt;
                    fft_m_valid = 1'b1;
                end else if (burst_start >= 0 && cyc >= burst_start) begin
                    fft_m_valid = 1'b1;
                    fft_k = K_W'(burst_i);
                    burst_i++;
                    if (burst_i == FL && stop_last_cnt != seen_last) begin
                        seen_last = stop_last_cnt;
                        stop = 1'b1;
                    end
                    if (burst_i >= res_limit) burst_start = -1;
                end
            end
        end
    end

    // Reference model: applies the sequencing rules to the stimulus seen at
    // each clock edge and queues the responses the DUT owes.
    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                running = 0; feeding = 0; stop_req = 0; exp_terr = 0; exp_serr = 0;
                got = 0; beats = 0; idle = 0; frames = 0;
                exp_s.delete();
                exp_m.delete();
            end else if (!running) begin
                if (fft_m_valid) exp_serr = 1;
                if (start) begin
                    running = 1; feeding = 1; got = 0; frames = 0;
                    exp_terr = 0; exp_serr = 0; stop_req = 0;
                end
            end else if (feeding) begin
                if (fft_m_valid) exp_serr = 1;
                if (stop) stop_req = 1;
                if (adc_valid) begin
                    exp_s.push_back({adc_d3, adc_d2, adc_d1, adc_d0});
                    got++;
                    if (got == FL) begin
                        feeding = 0; got = 0; beats = 0; idle = 0;
                    end
                end
            end else begin
                if (stop) stop_req = 1;
                if (fft_m_valid) begin
                    idle = 0;
                    beats++;
                    exp_m.push_back({beats == FL, fft_k, fo3, fo2, fo1, fo0});
                    if (beats == FL) begin
                        beats = 0;
                        frames++;
                        if (cont_mode && !stop_req && (n_frames == 0 || frames < int'(n_frames)))
                            feeding = 1;
                        else begin
                            running = 0;
                            stop_req = 0;
                        end
                    end
                end else begin
                    idle++;
                    if (idle == TO) begin
                        running = 0;
                        exp_terr = 1;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat and
    // compares status outputs against the model every cycle.
    initial begin
        logic [4*IN_W-1:0] es;
        logic [270:0] em;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (fft_s_valid) begin
                    n_sv++;
                    if (exp_s.size() == 0) chk("unexpected_fft_s_valid", 1, 0);
                    else begin
                        es = exp_s.pop_front();
                        chk("fft_data_in", {fin3, fin2, fin1, fin0}, es);
                    end
                end
                if (m_valid) begin
                    n_mv++;
                    if (m_last) n_last++;
                    if (exp_m.size() == 0) chk("unexpected_m_valid", 1, 0);
                    else begin
                        em = exp_m.pop_front();
                        chk("m_beat", {m_last, m_k, md3, md2, md1, md0}, em);
                    end
                end else begin
                    chk("m_last_without_valid", m_last, 0);
                end
                chk("busy", busy, running);
                chk("frame_cnt", frame_cnt, 16'(frames));
                chk("timeout_err", timeout_err, exp_terr);
                chk("stray_err", stray_err, exp_serr);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        @(negedge clk);
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
        end
    endtask

    // Runs one sequence from IDLE and checks beat totals.
    task automatic run_seq(input string name, input bit cm, input int nf, input int mode,
                           input int exp_frames, input int exp_sv, input int exp_mv);
        int sv0, mv0, l0;
        cont_mode = cm;
        n_frames = 16'(nf);
        adc_mode = mode;
        sv0 = n_sv; mv0 = n_mv; l0 = n_last;
        pulse_start();
        wait_idle(3000);
        adc_mode = 0;
        repeat (2) @(negedge clk);
        chk({name, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
        chk({name, "_s_pulses"}, 32'(n_sv - sv0), 32'(exp_sv));
        chk({name, "_m_beats"}, 32'(n_mv - mv0), 32'(exp_mv));
        chk({name, "_m_lasts"}, 32'(n_last - l0), 32'(exp_frames));
        chk({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_fft_data_in", {fin3, fin2, fin1, fin0}, 0);
        chk("rst_m_data", {md3, md2, md1, md0}, 0);
        chk("rst_ctrl", {fft_s_valid, m_k, m_valid, m_last, busy, frame_cnt,
                         timeout_err, stray_err}, 0);
        @(negedge clk); #2 resetn = 1'b1;
        repeat (3) @(negedge clk);

        run_seq("single", 0, 0, 1, 1, FL, FL);
        run_seq("gappy", 0, 0, 2, 1, FL, FL);
        run_seq("cont3", 1, 3, 1, 3, 3 * FL, 3 * FL);

        // Stop during FEED: the frame still completes.
        cont_mode = 1'b1; n_frames = '0; adc_mode = 1;
        pulse_start();
        repeat (6) @(negedge clk);
        stop_now_cnt++;
        wait_idle(3000);
        adc_mode = 0;
        @(negedge clk);
        chk("stop_feed_frame_cnt", frame_cnt, 1);

        // Stop together with the final result beat.
        stop_last_cnt++;
        run_seq("stop_last", 1, 0, 1, 1, FL, FL);

        // Stop while idle leaves nothing pending.
        stop_now_cnt++;
        repeat (3) @(negedge clk);
        run_seq("idle_stop", 1, 2, 1, 2, 2 * FL, 2 * FL);

        // Drain timeout after only 10 results.
        res_limit = 10;
        run_seq("timeout", 0, 0, 1, 0, FL, 10);
        chk("timeout_err_set", timeout_err, 1);
        res_limit = FL;
        pulse_start();
        @(negedge clk);
        chk("timeout_err_cleared", timeout_err, 0);
        adc_mode = 1;
        wait_idle(3000);
        adc_mode = 0;

        // Stray result beat while idle.
        repeat (2) @(negedge clk);
        stray_cnt++;
        repeat (3) @(negedge clk);
        chk("stray_err_set", stray_err, 1);
        chk("stray_no_forward", m_valid, 0);
        run_seq("after_stray", 0, 0, 1, 1, FL, FL);

        // Asynchronous reset in the middle of FEED.
        cont_mode = 1'b0; adc_mode = 1;
        pulse_start();
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_data_in", {fin3, fin2, fin1, fin0}, 0);
        chk("async_rst_ctrl", {fft_s_valid, m_valid, m_last, busy, frame_cnt}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 resetn = 1'b1;
        adc_mode = 0;
        repeat (3) @(negedge clk);

        // Randomized sequences.
        for (int i = 0; i < 4; i++) begin
            int nf;
            nf = $urandom_range(1, 3);
            run_seq("rand", 1, nf, $urandom_range(1, 3), nf, nf * FL, nf * FL);
        end

        chk("s_queue_empty", 32'(exp_s.size()), 0);
        chk("m_queue_empty", 32'(exp_m.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
